// File: rtl/rob_mp_pkg.sv
// Shared types for the multi-port reorder buffer: entry layout, FSM states and ID width.
package rob_mp_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned ARF_ID_WIDTH   = 5;
  localparam int unsigned PC_WIDTH       = 32;

  typedef struct packed {
    logic                    dst_valid;
    logic [ARF_ID_WIDTH-1:0] dst_arf_id;
    logic [PC_WIDTH-1:0]     pc;
  } rob_dispatch_data_t;

  typedef struct packed {
    logic                      valid;
    logic                      dst_valid;
    logic [ARF_ID_WIDTH-1:0]   dst_arf_id;
    logic [PC_WIDTH-1:0]       pc;
    logic [PC_WIDTH-1:0]       npc;
    logic                      done;
    logic [REG_DATA_WIDTH-1:0] reg_data;
    logic                      br_mispred;
    logic                      ld_mispred;
  } rob_mp_entry_t;

  typedef enum logic {RUN, FLUSH} rob_state_e;

  function automatic int unsigned rob_id_width(input int unsigned n_entries);
    return $clog2(n_entries);
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire selection over the head window, with mispredict detection and redirect.
module rob_retire_sel
  import rob_mp_pkg::*;
#(
  parameter int unsigned RETIRE_W = 2,
  parameter int unsigned CNT_W    = 5
) (
  input  rob_mp_entry_t       head_entries_i [RETIRE_W],
  input  logic [CNT_W-1:0]    count_i,
  input  logic                enable_i,
  output logic [RETIRE_W-1:0] retire_mask_o,
  output logic                redirect_valid_o,
  output logic [PC_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]    retire_cnt_o
);

  always_comb begin
    logic stop;
    stop             = !enable_i;
    retire_mask_o    = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    retire_cnt_o     = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (!stop) begin
        if (CNT_W'(k) >= count_i || !head_entries_i[k].valid || !head_entries_i[k].done) begin
          stop = 1'b1;
        end else if (head_entries_i[k].ld_mispred) begin
          // Load replay: the entry itself is re-fetched, so it must not retire.
          redirect_valid_o = 1'b1;
          redirect_pc_o    = head_entries_i[k].pc;
          stop             = 1'b1;
        end else begin
          retire_mask_o[k] = 1'b1;
          retire_cnt_o     = retire_cnt_o + 1'b1;
          if (head_entries_i[k].br_mispred) begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = head_entries_i[k].npc;
            stop             = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rob_mp.sv
// Multi-port reorder buffer: enqueue, multi-port writeback with read bypass,
// in-order multi-retire and precise flush on mispredict.
module rob_mp
  import rob_mp_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned N_WB      = 3,
  parameter int unsigned N_RD      = 2,
  parameter int unsigned RETIRE_W  = 2,
  localparam int unsigned ID_W     = rob_id_width(N_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_valid,
  output logic                      dispatch_ready,
  input  rob_dispatch_data_t        dispatch_data,
  output logic [ID_W-1:0]           dispatch_rob_id,
  input  logic [ID_W-1:0]           rd_rob_id       [N_RD],
  output logic                      rd_ready        [N_RD],
  output logic [REG_DATA_WIDTH-1:0] rd_data         [N_RD],
  input  logic                      wb_valid        [N_WB],
  input  logic [ID_W-1:0]           wb_rob_id       [N_WB],
  input  logic [REG_DATA_WIDTH-1:0] wb_reg_data     [N_WB],
  input  logic                      wb_br_mispred   [N_WB],
  input  logic                      wb_ld_mispred   [N_WB],
  input  logic [PC_WIDTH-1:0]       wb_npc          [N_WB],
  output logic                      retire_valid    [RETIRE_W],
  output logic [ID_W-1:0]           retire_rob_id   [RETIRE_W],
  output logic                      retire_we       [RETIRE_W],
  output logic [ARF_ID_WIDTH-1:0]   retire_arf_id   [RETIRE_W],
  output logic [REG_DATA_WIDTH-1:0] retire_reg_data [RETIRE_W],
  output logic                      redirect_valid,
  output logic [PC_WIDTH-1:0]       redirect_pc
);

  rob_mp_entry_t entries_q [N_ENTRIES];
  rob_mp_entry_t entries_d [N_ENTRIES];
  rob_mp_entry_t head_entries [RETIRE_W];
  logic [ID_W:0] head_q, head_d, tail_q, tail_d, count, retire_cnt;
  rob_state_e    state_q, state_d;
  logic [RETIRE_W-1:0] retire_mask;
  logic run, full, enq;

  assign run             = (state_q == RUN);
  assign count           = tail_q - head_q;
  assign full            = count[ID_W];
  assign dispatch_ready  = run && !full;
  assign dispatch_rob_id = tail_q[ID_W-1:0];
  assign enq             = dispatch_valid && dispatch_ready;

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      head_entries[k]    = entries_q[head_q[ID_W-1:0] + ID_W'(k)];
      retire_valid[k]    = retire_mask[k];
      retire_rob_id[k]   = head_q[ID_W-1:0] + ID_W'(k);
      retire_we[k]       = retire_mask[k] && head_entries[k].dst_valid;
      retire_arf_id[k]   = head_entries[k].dst_arf_id;
      retire_reg_data[k] = head_entries[k].reg_data;
    end
  end

  rob_retire_sel #(
    .RETIRE_W (RETIRE_W),
    .CNT_W    (ID_W + 1)
  ) u_retire_sel (
    .head_entries_i   (head_entries),
    .count_i          (count),
    .enable_i         (run),
    .retire_mask_o    (retire_mask),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .retire_cnt_o     (retire_cnt)
  );

  // Same-cycle writeback bypass; the highest-index matching port wins.
  always_comb begin
    for (int r = 0; r < N_RD; r++) begin
      rd_ready[r] = entries_q[rd_rob_id[r]].valid && entries_q[rd_rob_id[r]].done;
      rd_data[r]  = entries_q[rd_rob_id[r]].reg_data;
      for (int p = 0; p < N_WB; p++) begin
        if (wb_valid[p] && wb_rob_id[p] == rd_rob_id[r]) begin
          rd_ready[r] = 1'b1;
          rd_data[r]  = wb_reg_data[p];
        end
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + retire_cnt;
    tail_d    = tail_q;
    state_d   = RUN;
    if (run) begin
      for (int p = 0; p < N_WB; p++) begin
        if (wb_valid[p] && entries_q[wb_rob_id[p]].valid) begin
          entries_d[wb_rob_id[p]].done       = 1'b1;
          entries_d[wb_rob_id[p]].reg_data   = wb_reg_data[p];
          entries_d[wb_rob_id[p]].npc        = wb_npc[p];
          entries_d[wb_rob_id[p]].br_mispred = wb_br_mispred[p];
          entries_d[wb_rob_id[p]].ld_mispred = wb_ld_mispred[p];
        end
      end
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      if (retire_mask[k]) entries_d[head_q[ID_W-1:0] + ID_W'(k)].valid = 1'b0;
    end
    if (enq) begin
      entries_d[tail_q[ID_W-1:0]]            = '0;
      entries_d[tail_q[ID_W-1:0]].valid      = 1'b1;
      entries_d[tail_q[ID_W-1:0]].dst_valid  = dispatch_data.dst_valid;
      entries_d[tail_q[ID_W-1:0]].dst_arf_id = dispatch_data.dst_arf_id;
      entries_d[tail_q[ID_W-1:0]].pc         = dispatch_data.pc;
      tail_d = tail_q + 1'b1;
    end
    // Flush overrides any same-cycle enqueue.
    if (redirect_valid) begin
      for (int i = 0; i < N_ENTRIES; i++) entries_d[i].valid = 1'b0;
      tail_d  = head_d;
      state_d = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= RUN;
      for (int i = 0; i < N_ENTRIES; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      state_q   <= state_d;
      entries_q <= entries_d;
    end
  end

endmodule
